// File: rtl/blk_pkg.sv
// Shared definitions for the highlight-suppression Gaussian stage.
// Holds the frame sequencer state encoding and the constants that the
// controller and the Gaussian datapath must agree on.
package blk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    LINE  = 2'd2,
    DONE  = 2'd3
  } frame_state_t;

  // Leading rows/columns where the 3x3 window is incomplete.
  localparam int HL_BORDER    = 2;
  // Threshold in force after reset.
  localparam int HL_THRESHOLD = 220;

endpackage

// File: rtl/sync_edge_det.sv
// Registered edge detector for one frame-sync signal.
// The input is registered once, then delayed once more; rise and fall are
// decoded from the registered value and its delay.
//   clk, rst_n : clock, async active-low reset
//   din        : raw sync input
//   rise, fall : one-cycle pulses, aligned with the first registered sample
//                of the new level
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic q;
  logic q_d;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= din;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/highlight_frame_ctrl.sv
// Frame sequencer and configuration controller for the highlight
// suppression Gaussian stage.
//   clk, rst_n                      : pixel clock, async active-low reset
//   per_frame_vsync/hsync/href      : frame, line and active-pixel syncs
//   hl_flag                         : highlight detect for the current pixel
//   cfg_threshold, cfg_enable       : requested settings (shadowed per frame)
//   cfg_stat_clr                    : clears geom_err and reference geometry
//   act_threshold, act_enable       : settings in force for this frame
//   pix_col, pix_row, pix_border    : coordinates and border mask, 2-cycle
//   filt_sel                        : filter select (enable and not border)
//   frame_done                      : one-cycle pulse at frame end
//   frame_width, frame_height       : geometry of the last frame
//   hl_count                        : highlight pixels in the last frame
//   geom_err                        : sticky geometry / truncation error
module highlight_frame_ctrl
  import blk_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int THRESHOLD  = HL_THRESHOLD,
  parameter int COL_W      = 12,
  parameter int ROW_W      = 11,
  parameter int CNT_W      = 22,
  parameter int BORDER     = HL_BORDER
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_hsync,
  input  logic                  per_frame_href,
  input  logic                  hl_flag,
  input  logic [DATA_WIDTH-1:0] cfg_threshold,
  input  logic                  cfg_enable,
  input  logic                  cfg_stat_clr,
  output logic [DATA_WIDTH-1:0] act_threshold,
  output logic                  act_enable,
  output logic [COL_W-1:0]      pix_col,
  output logic [ROW_W-1:0]      pix_row,
  output logic                  pix_border,
  output logic                  filt_sel,
  output logic                  frame_done,
  output logic [COL_W-1:0]      frame_width,
  output logic [ROW_W-1:0]      frame_height,
  output logic [CNT_W-1:0]      hl_count,
  output logic                  geom_err
);

  // hsync only matters for downstream alignment; coordinates come from href.
  logic unused_hsync;
  assign unused_hsync = per_frame_hsync;

  logic vs_rise, vs_fall, hr_rise, hr_fall;
  logic hl_flag_r;

  sync_edge_det u_vsync_det (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (per_frame_vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  sync_edge_det u_href_det (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (per_frame_href),
    .rise (hr_rise),
    .fall (hr_fall)
  );

  // Same single register stage as href, so the flag lines up with its pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hl_flag_r <= 1'b0;
    else        hl_flag_r <= hl_flag;
  end

  frame_state_t        state, state_nxt;
  logic [CNT_W-1:0]    hl_cnt, hl_nxt, hl_inc;
  logic [COL_W-1:0]    line_width, lw_nxt, col_nxt, col_inc;
  logic [ROW_W-1:0]    row_nxt, row_inc;
  logic                load_cfg, done_evt, trunc;
  logic                border_nxt, act_en_nxt;
  logic [COL_W-1:0]    ref_w;
  logic [ROW_W-1:0]    ref_h;
  logic                ref_valid, geom_mismatch;

  // Saturating increments; col_inc doubles as the width of a line whose
  // last pixel sits at pix_col.
  assign col_inc = (&pix_col) ? pix_col : pix_col + 1'b1;
  assign row_inc = (&pix_row) ? pix_row : pix_row + 1'b1;
  assign hl_inc  = (&hl_cnt)  ? hl_cnt  : hl_cnt + 1'b1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    col_nxt   = pix_col;
    row_nxt   = pix_row;
    hl_nxt    = hl_cnt;
    lw_nxt    = line_width;
    load_cfg  = 1'b0;
    done_evt  = 1'b0;
    trunc     = 1'b0;
    case (state)
      IDLE: begin
        if (vs_rise) begin
          state_nxt = FRAME;
          load_cfg  = 1'b1;
          col_nxt   = '0;
          row_nxt   = '0;
          hl_nxt    = '0;
          lw_nxt    = '0;
        end
      end
      FRAME: begin
        if (vs_fall) begin
          state_nxt = DONE;
          done_evt  = 1'b1;
        end else if (hr_rise) begin
          state_nxt = LINE;
          col_nxt   = '0;
          if (hl_flag_r) hl_nxt = hl_inc;
        end
      end
      LINE: begin
        if (vs_fall || hr_fall) begin
          lw_nxt  = col_inc;
          row_nxt = row_inc;
          if (vs_fall) begin
            state_nxt = DONE;
            done_evt  = 1'b1;
            // href still high when the frame ends: the line was cut short.
            trunc     = ~hr_fall;
          end else begin
            state_nxt = FRAME;
          end
        end else begin
          col_nxt = col_inc;
          if (hl_flag_r) hl_nxt = hl_inc;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign border_nxt = (row_nxt < ROW_W'(BORDER)) || (col_nxt < COL_W'(BORDER));
  assign act_en_nxt = load_cfg ? cfg_enable : act_enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pix_col       <= '0;
      pix_row       <= '0;
      pix_border    <= 1'b0;
      filt_sel      <= 1'b0;
      hl_cnt        <= '0;
      line_width    <= '0;
      act_threshold <= DATA_WIDTH'(THRESHOLD);
      act_enable    <= 1'b1;
      frame_done    <= 1'b0;
      frame_width   <= '0;
      frame_height  <= '0;
      hl_count      <= '0;
    end else begin
      state      <= state_nxt;
      pix_col    <= col_nxt;
      pix_row    <= row_nxt;
      pix_border <= border_nxt;
      filt_sel   <= act_en_nxt & ~border_nxt;
      hl_cnt     <= hl_nxt;
      line_width <= lw_nxt;
      frame_done <= done_evt;
      if (load_cfg) begin
        act_threshold <= cfg_threshold;
        act_enable    <= cfg_enable;
      end
      if (done_evt) begin
        frame_width  <= lw_nxt;
        frame_height <= row_nxt;
        hl_count     <= hl_nxt;
      end
    end
  end

  assign geom_mismatch = ref_valid && ((lw_nxt != ref_w) || (row_nxt != ref_h));

  // A clear coinciding with frame end adopts that frame as the new reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_valid <= 1'b0;
      ref_w     <= '0;
      ref_h     <= '0;
      geom_err  <= 1'b0;
    end else if (cfg_stat_clr) begin
      geom_err  <= 1'b0;
      ref_valid <= done_evt;
      if (done_evt) begin
        ref_w <= lw_nxt;
        ref_h <= row_nxt;
      end
    end else if (done_evt) begin
      if (!ref_valid) begin
        ref_valid <= 1'b1;
        ref_w     <= lw_nxt;
        ref_h     <= row_nxt;
      end
      if (geom_mismatch || trunc) geom_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_highlight_frame_ctrl.sv
// Directed bench for highlight_frame_ctrl. Inputs are driven on the falling
// edge; outputs are read on the falling edge before the next drive. A
// pixel driven at one falling edge shows up on pix_* two falling edges later.
module tb_highlight_frame_ctrl;

  localparam int DW = 8;
  localparam int CW = 12;
  localparam int RW = 11;
  localparam int NW = 22;

  logic          clk;
  logic          rst_n;
  logic          per_frame_vsync;
  logic          per_frame_hsync;
  logic          per_frame_href;
  logic          hl_flag;
  logic [DW-1:0] cfg_threshold;
  logic          cfg_enable;
  logic          cfg_stat_clr;
  logic [DW-1:0] act_threshold;
  logic          act_enable;
  logic [CW-1:0] pix_col;
  logic [RW-1:0] pix_row;
  logic          pix_border;
  logic          filt_sel;
  logic          frame_done;
  logic [CW-1:0] frame_width;
  logic [RW-1:0] frame_height;
  logic [NW-1:0] hl_count;
  logic          geom_err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  bit chk_pix = 0;
  bit chk_border = 0;
  bit tag_v [2];
  int tag_r [2];
  int tag_c [2];

  highlight_frame_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_frame_vsync(per_frame_vsync),
    .per_frame_hsync(per_frame_hsync),
    .per_frame_href (per_frame_href),
    .hl_flag        (hl_flag),
    .cfg_threshold  (cfg_threshold),
    .cfg_enable     (cfg_enable),
    .cfg_stat_clr   (cfg_stat_clr),
    .act_threshold  (act_threshold),
    .act_enable     (act_enable),
    .pix_col        (pix_col),
    .pix_row        (pix_row),
    .pix_border     (pix_border),
    .filt_sel       (filt_sel),
    .frame_done     (frame_done),
    .frame_width    (frame_width),
    .frame_height   (frame_height),
    .hl_count       (hl_count),
    .geom_err       (geom_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; also checks the pixel driven two steps earlier.
  task automatic step(input logic vs, input logic hr, input logic hl,
                      input bit tv, input int tr, input int tc);
    bit hit;
    logic exp_b, exp_f;
    @(negedge clk);
    if (frame_done === 1'b1) done_cnt++;
    if (chk_pix && tag_v[1]) begin
      n_cmp++;
      if (pix_col !== CW'(tag_c[1]) || pix_row !== RW'(tag_r[1])) begin
        n_bad++;
        $display("FAIL pix_coord: got row %0d col %0d, want row %0d col %0d",
                 pix_row, pix_col, tag_r[1], tag_c[1]);
      end
    end
    if (chk_border && tag_v[1]) begin
      hit = 1'b1;
      exp_b = 1'b0;
      exp_f = 1'b0;
      if (tag_r[1] == 0 && tag_c[1] == 5)      begin exp_b = 1'b1; exp_f = 1'b0; end
      else if (tag_r[1] == 3 && tag_c[1] == 1) begin exp_b = 1'b1; exp_f = 1'b0; end
      else if (tag_r[1] == 3 && tag_c[1] == 2) begin exp_b = 1'b0; exp_f = 1'b1; end
      else hit = 1'b0;
      if (hit) begin
        n_cmp++;
        if (pix_border !== exp_b || filt_sel !== exp_f) begin
          n_bad++;
          $display("FAIL border(%0d,%0d): got border %b filt %b, want border %b filt %b",
                   tag_r[1], tag_c[1], pix_border, filt_sel, exp_b, exp_f);
        end
      end
    end
    tag_v[1] = tag_v[0]; tag_r[1] = tag_r[0]; tag_c[1] = tag_c[0];
    tag_v[0] = tv;       tag_r[0] = tr;       tag_c[0] = tc;
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_hsync = hr;
    hl_flag         = hl;
  endtask

  task automatic frame_start();
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Row 1 carries the highlight pixels: the first five of the line.
  task automatic frame_line(input int w, input int r);
    for (int c = 0; c < w; c++)
      step(1'b1, 1'b1, logic'(r == 1 && c < 5), 1'b1, r, c);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // vsync falls; frame_done must appear exactly two cycles later, one cycle wide.
  task automatic frame_end();
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL done_early: got %b want 0", frame_done); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (frame_done !== 1'b1) begin n_bad++; $display("FAIL done_pulse: got %b want 1", frame_done); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL done_width: got %b want 0", frame_done); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic full_frame(input int w, input int h);
    frame_start();
    for (int r = 0; r < h; r++) frame_line(w, r);
    frame_end();
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({act_threshold, act_enable} !== {8'd220, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_act: got thr %0d en %b, want thr 220 en 1", act_threshold, act_enable);
    end
    n_cmp++;
    if ({pix_col, pix_row, pix_border, filt_sel, frame_done} !== '0) begin
      n_bad++;
      $display("FAIL reset_pix: got col %0d row %0d b %b f %b d %b, want all 0",
               pix_col, pix_row, pix_border, filt_sel, frame_done);
    end
    n_cmp++;
    if ({frame_width, frame_height, hl_count, geom_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_stat: got w %0d h %0d hl %0d err %b, want all 0",
               frame_width, frame_height, hl_count, geom_err);
    end
  endtask

  task automatic test_two_frames();
    int d0;
    d0 = done_cnt;
    chk_pix = 1'b1;
    full_frame(8, 6);
    chk_pix = 1'b0;
    n_cmp++;
    if ({frame_width, frame_height, hl_count, geom_err} !== {12'd8, 11'd6, 22'd5, 1'b0}) begin
      n_bad++;
      $display("FAIL frame1_stats: got w %0d h %0d hl %0d err %b, want 8 6 5 0",
               frame_width, frame_height, hl_count, geom_err);
    end
    full_frame(8, 6);
    n_cmp++;
    if ({frame_width, frame_height, hl_count, geom_err} !== {12'd8, 11'd6, 22'd5, 1'b0}) begin
      n_bad++;
      $display("FAIL frame2_stats: got w %0d h %0d hl %0d err %b, want 8 6 5 0",
               frame_width, frame_height, hl_count, geom_err);
    end
    n_cmp++;
    if (done_cnt !== d0 + 2) begin n_bad++; $display("FAIL done_count: got %0d want %0d", done_cnt - d0, 2); end
  endtask

  task automatic test_cfg_shadow();
    frame_start();
    n_cmp++;
    if (act_threshold !== 8'd220) begin n_bad++; $display("FAIL thr_start: got %0d want 220", act_threshold); end
    for (int r = 0; r < 3; r++) frame_line(8, r);
    cfg_threshold = 8'd200;
    for (int r = 3; r < 6; r++) frame_line(8, r);
    n_cmp++;
    if (act_threshold !== 8'd220) begin n_bad++; $display("FAIL thr_midframe: got %0d want 220", act_threshold); end
    frame_end();
    n_cmp++;
    if (act_threshold !== 8'd220) begin n_bad++; $display("FAIL thr_after_end: got %0d want 220", act_threshold); end
    frame_start();
    n_cmp++;
    if (act_threshold !== 8'd200) begin n_bad++; $display("FAIL thr_next_frame: got %0d want 200", act_threshold); end
    for (int r = 0; r < 6; r++) frame_line(8, r);
    frame_end();
    n_cmp++;
    if (geom_err !== 1'b0) begin n_bad++; $display("FAIL shadow_geom: got %b want 0", geom_err); end
  endtask

  task automatic test_border();
    chk_border = 1'b1;
    full_frame(8, 6);
    chk_border = 1'b0;
  endtask

  task automatic test_geom_mismatch();
    full_frame(8, 5);
    n_cmp++;
    if ({frame_width, frame_height, geom_err} !== {12'd8, 11'd5, 1'b1}) begin
      n_bad++;
      $display("FAIL mismatch_set: got w %0d h %0d err %b, want 8 5 1", frame_width, frame_height, geom_err);
    end
    cfg_stat_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    cfg_stat_clr = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (geom_err !== 1'b0) begin n_bad++; $display("FAIL stat_clr: got %b want 0", geom_err); end
    full_frame(8, 5);
    n_cmp++;
    if ({frame_height, geom_err} !== {11'd5, 1'b0}) begin
      n_bad++;
      $display("FAIL new_ref: got h %0d err %b, want 5 0", frame_height, geom_err);
    end
  endtask

  task automatic test_truncated();
    frame_start();
    frame_line(8, 0);
    frame_line(8, 1);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b0, 1'b1, 2, c);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if ({frame_done, frame_height, geom_err} !== {1'b1, 11'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL truncated: got done %b h %0d err %b, want 1 3 1", frame_done, frame_height, geom_err);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_reset_midframe();
    int d0;
    frame_start();
    for (int r = 0; r < 3; r++) frame_line(8, r);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 1'b0, 1'b1, 3, c);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_hsync = 1'b0;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (done_cnt !== d0) begin n_bad++; $display("FAIL reset_no_done: got %0d pulses want 0", done_cnt - d0); end
    full_frame(8, 6);
    n_cmp++;
    if ({frame_width, frame_height, hl_count, geom_err} !== {12'd8, 11'd6, 22'd5, 1'b0}) begin
      n_bad++;
      $display("FAIL post_reset_frame: got w %0d h %0d hl %0d err %b, want 8 6 5 0",
               frame_width, frame_height, hl_count, geom_err);
    end
    n_cmp++;
    if (act_threshold !== 8'd200) begin n_bad++; $display("FAIL post_reset_thr: got %0d want 200", act_threshold); end
  endtask

  initial begin
    rst_n           = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_hsync = 1'b0;
    per_frame_href  = 1'b0;
    hl_flag         = 1'b0;
    cfg_threshold   = 8'd220;
    cfg_enable      = 1'b1;
    cfg_stat_clr    = 1'b0;
    for (int i = 0; i < 2; i++) begin tag_v[i] = 1'b0; tag_r[i] = 0; tag_c[i] = 0; end
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    test_two_frames();
    test_cfg_shadow();
    test_border();
    test_geom_mismatch();
    test_truncated();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
